muldiv_sequencer: RTL
=====================

Name: muldiv_sequencer

Overview:
Iterative MIPS MULT/MULTU/DIV/DIVU unit that owns no adder of its own. It sequences the shared 32-bit ALU using only the ADD (4'b0010) and SUB (4'b0110) controls, one ALU operation per cycle, and produces HI/LO. It sits beside the execute stage; the parent muxes the ALU inputs to this block while busy=1.

Parameters:
WIDTH, 32, operand/ALU width; iteration count = WIDTH.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  request; accepted only in IDLE or DONE
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
rs_val  in  WIDTH  multiplicand / dividend
rt_val  in  WIDTH  multiplier / divisor
busy  out  1  operation in progress
done  out  1  one-cycle pulse, results valid
hi  out  WIDTH  product high / remainder
lo  out  WIDTH  product low / quotient
alu_in1  out  WIDTH  ALU operand 1
alu_in2  out  WIDTH  ALU operand 2
alu_control  out  4  ALU control, 4'b0010 or 4'b0110 only
alu_result  in  WIDTH  combinational ALU result, same cycle

Behaviour:
- Reset: state=IDLE; busy=0, done=0, hi=0, lo=0, alu_in1=0, alu_in2=0, alu_control=4'b0010.
- States: IDLE, NEG_A, NEG_B, ITER, FIX_LO, FIX_HI, DONE.
- Start accepted in cycle 0: latch op, rs_val, rt_val. Unsigned ops go to ITER and signed ops go to NEG_A. Start in any other state is ignored.
- NEG_A / NEG_B (signed only, always visited): replace operand with its magnitude.
  - Negative operand: 0 - x via SUB.
  - Otherwise: x + 0 via ADD.
  - 0x80000000 maps to 0x80000000, interpreted unsigned.
- ITER: exactly WIDTH cycles, counter 0..WIDTH-1.
  - Multiply: lo initialised to the multiplier, hi=0. If lo[0]=1, ALU computes hi+mcand and carry = (alu_result < hi). Then {carry,sum,lo} shifts right by 1. If lo[0]=0, {0,hi,lo} shifts right by 1.
  - Divide (restoring): hi=0, lo initialised to the dividend. s = {hi[WIDTH-2:0], lo[WIDTH-1]} and t = hi[WIDTH-1]. ALU computes s - divisor. If t or s >= divisor: hi = diff, lo = {lo<<1, 1}. Otherwise hi = s, lo = {lo<<1, 0}.
- FIX_LO / FIX_HI (signed only, always visited):
  - neg = sign(rs) xor sign(rt).
  - FIX_LO: lo = neg ? 0 - lo : lo + 0.
  - FIX_HI, multiply: hi = neg ? ~hi + (lo==0) : hi + 0.
  - FIX_HI, divide: hi = sign(rs) ? 0 - hi : hi + 0 (remainder follows the dividend).
- DONE: done=1 for one cycle, busy=0, then IDLE. hi/lo hold until the next accepted start.
- Fixed latency, start sampled in cycle 0:
  - Unsigned: done in cycle WIDTH+1 (33).
  - Signed: done in cycle WIDTH+5 (37).
  - busy=1 from cycle 1 through the cycle before done.
- Back-to-back: start during DONE is accepted, so the next operation's cycle 0 is the DONE cycle.
- Divide by zero needs no special case. The algorithm yields lo = all ones and hi = dividend magnitude, then signed fixups apply.
- Reset mid-operation: IDLE next cycle with all outputs at reset values. No done pulse is produced.
- alu_in1/alu_in2/alu_control are don't-care for the parent while busy=0, but are driven to ADD 0+0 there.

Optional Feature:
MULDIV_DIV0_FLAG_EN
- Defined: adds output port div0 (1 bit). It is registered at start for DIV/DIVU with rt_val==0, equals 0 for multiplies, and holds until the next start.
- Not defined: the port does not exist. Results are identical either way.

Decomposition:
- Package muldiv_pkg: op encodings, state enum, ALU_CTRL_ADD=4'b0010, ALU_CTRL_SUB=4'b0110.
- No sub-module. The single FSM plus datapath registers are in one module, and the ALU is instantiated by the parent.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done at cycle 33 exactly, busy cycles 1-32.
- MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, done at cycle 37; MULT 0x80000000*2 -> hi=0xFFFFFFFF, lo=0x00000000.
- DIVU 100/7 -> lo=14, hi=2; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
- DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x1234; with MULDIV_DIV0_FLAG_EN, div0=1.
- start pulsed at cycle 5 of a running op -> ignored, original result unchanged; start on the DONE cycle -> new op accepted, second done 33 cycles later.
- reset asserted at cycle 10 of DIVU -> cycle 11 busy=0, hi=lo=0, no done; fresh MULTU 6*7 afterwards -> lo=42, hi=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
// Holds the op codes, the shared-ALU control codes and the sequencer state enum.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [3:0] ALU_CTRL_ADD = 4'b0010;
  localparam logic [3:0] ALU_CTRL_SUB = 4'b0110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NEG_A,
    S_NEG_B,
    S_ITER,
    S_FIX_LO,
    S_FIX_HI,
    S_DONE
  } state_t;

endpackage

// File: rtl/muldiv_sequencer.sv
// MULT/MULTU/DIV/DIVU sequencer driving the shared ALU with ADD/SUB only, one op per cycle.
// Optional MULDIV_DIV0_FLAG_EN adds a registered divide-by-zero flag output div0.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result
`ifdef MULDIV_DIV0_FLAG_EN
  , output logic           div0
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a, b;
  logic             is_div, is_sgn, sa, sb;
  logic             accept, neg;
  logic [WIDTH-1:0] s;
  logic             t, ge, carry;

  // s/t form the restoring-division partial remainder shifted left by one bit
  assign s      = {hi[WIDTH-2:0], lo[WIDTH-1]};
  assign t      = hi[WIDTH-1];
  assign ge     = t | (s >= b);
  assign carry  = (alu_result < hi);
  assign neg    = sa ^ sb;
  assign accept = start && ((state == S_IDLE) || (state == S_DONE));
  assign busy   = (state != S_IDLE) && (state != S_DONE);
  assign done   = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    alu_in1     = '0;
    alu_in2     = '0;
    alu_control = ALU_CTRL_ADD;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept)               state_nx = op[0] ? S_ITER : S_NEG_A;
        else if (state == S_DONE) state_nx = S_IDLE;
      end
      S_NEG_A: begin
        if (a[WIDTH-1]) begin alu_in2 = a; alu_control = ALU_CTRL_SUB; end
        else            alu_in1 = a;
        state_nx = S_NEG_B;
      end
      S_NEG_B: begin
        if (b[WIDTH-1]) begin alu_in2 = b; alu_control = ALU_CTRL_SUB; end
        else            alu_in1 = b;
        state_nx = S_ITER;
      end
      S_ITER: begin
        if (is_div) begin
          alu_in1     = s;
          alu_in2     = b;
          alu_control = ALU_CTRL_SUB;
        end else begin
          alu_in1 = hi;
          alu_in2 = a;
        end
        if (cnt == LAST) state_nx = is_sgn ? S_FIX_LO : S_DONE;
      end
      S_FIX_LO: begin
        if (neg) begin alu_in2 = lo; alu_control = ALU_CTRL_SUB; end
        else     alu_in1 = lo;
        state_nx = S_FIX_HI;
      end
      S_FIX_HI: begin
        // lo is already negated here; lo==0 still marks the carry into the high word
        if (is_div) begin
          if (sa) begin alu_in2 = hi; alu_control = ALU_CTRL_SUB; end
          else    alu_in1 = hi;
        end else if (neg) begin
          alu_in1 = ~hi;
          alu_in2 = {{(WIDTH-1){1'b0}}, (lo == '0)};
        end else begin
          alu_in1 = hi;
        end
        state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      is_sgn <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
      div0   <= 1'b0;
`endif
    end else if (accept) begin
      is_div <= op[1];
      is_sgn <= ~op[0];
      sa     <= rs_val[WIDTH-1];
      sb     <= rt_val[WIDTH-1];
      a      <= rs_val;
      b      <= rt_val;
      hi     <= '0;
      lo     <= op[1] ? rs_val : rt_val;
      cnt    <= '0;
`ifdef MULDIV_DIV0_FLAG_EN
      div0   <= op[1] && (rt_val == '0);
`endif
    end else begin
      case (state)
        S_NEG_A: a <= alu_result;
        S_NEG_B: begin
          b  <= alu_result;
          lo <= is_div ? a : alu_result;
        end
        S_ITER: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            hi <= ge ? alu_result : s;
            lo <= {lo[WIDTH-2:0], ge};
          end else if (lo[0]) begin
            hi <= {carry, alu_result[WIDTH-1:1]};
            lo <= {alu_result[0], lo[WIDTH-1:1]};
          end else begin
            hi <= {1'b0, hi[WIDTH-1:1]};
            lo <= {hi[0], lo[WIDTH-1:1]};
          end
        end
        S_FIX_LO: lo <= alu_result;
        S_FIX_HI: hi <= alu_result;
        default: ;
      endcase
    end
  end

endmodule
